// File: rtl/arp_rx_parser.sv
// ARP receive parser: hunts for preamble/SFD on a GMII-style byte stream,
// assembles Ethernet + ARP header fields in shadow registers and commits
// them to a held, read-back-able packet slot when the frame is a valid ARP.
module arp_rx_parser #(
    parameter bit MAC_FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_data,
    input  logic        i_data_vl,
    input  logic [47:0] i_my_mac,
    input  logic [3:0]  i_rd_addr,
    output logic [31:0] o_rd_data,
    input  logic        i_ack,
    output logic        o_pkt_ready,
    output logic        o_pkt_strobe,
    output logic [1:0]  o_oper
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, FIELDS, WAIT_END} state_t;

    localparam logic [5:0] LAST_IDX = 6'd41;

    state_t      state;
    logic [5:0]  idx;

    // shadow fields, filled byte by byte while the frame streams in
    logic [47:0] sh_dst, sh_src, sh_sha, sh_tha;
    logic [15:0] sh_etype, sh_htype, sh_ptype, sh_oper;
    logic [7:0]  sh_hlen, sh_plen;
    logic [31:0] sh_spa, sh_tpa;

    // visible (committed) packet
    logic [47:0] v_src, v_sha, v_tha;
    logic [31:0] v_spa, v_tpa;
    logic [7:0]  drop_cnt;

    logic dst_ok, pkt_ok, last_byte, commit_req, commit, drop;

    // Validity uses the completed shadow fields; by byte 41 only the last TPA
    // byte is still in flight and it does not take part in validation.
    always_comb begin
        dst_ok     = !MAC_FILTER || (sh_dst == i_my_mac) || (sh_dst == 48'hFFFF_FFFF_FFFF);
        pkt_ok     = (sh_etype == 16'h0806) && (sh_htype == 16'h0001) &&
                     (sh_ptype == 16'h0800) && (sh_hlen == 8'd6) && (sh_plen == 8'd4) &&
                     ((sh_oper == 16'd1) || (sh_oper == 16'd2)) && dst_ok;
        last_byte  = (state == FIELDS) && i_data_vl && (idx == LAST_IDX);
        commit_req = last_byte && pkt_ok;
        commit     = commit_req && (!o_pkt_ready || i_ack);
        drop       = commit_req && o_pkt_ready && !i_ack;
    end

    // Frame FSM and shadow-field assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            sh_dst   <= '0;
            sh_src   <= '0;
            sh_sha   <= '0;
            sh_tha   <= '0;
            sh_etype <= '0;
            sh_htype <= '0;
            sh_ptype <= '0;
            sh_oper  <= '0;
            sh_hlen  <= '0;
            sh_plen  <= '0;
            sh_spa   <= '0;
            sh_tpa   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_data_vl && i_data == 8'h55) state <= PREAMBLE;
                end
                PREAMBLE: begin
                    if (!i_data_vl)            state <= IDLE;
                    else if (i_data == 8'hD5) begin
                        state <= FIELDS;
                        idx   <= '0;
                    end else if (i_data != 8'h55) state <= WAIT_END;
                end
                FIELDS: begin
                    if (!i_data_vl) begin
                        state <= IDLE;
                    end else begin
                        if      (idx <= 6'd5)  sh_dst   <= {sh_dst[39:0], i_data};
                        else if (idx <= 6'd11) sh_src   <= {sh_src[39:0], i_data};
                        else if (idx <= 6'd13) sh_etype <= {sh_etype[7:0], i_data};
                        else if (idx <= 6'd15) sh_htype <= {sh_htype[7:0], i_data};
                        else if (idx <= 6'd17) sh_ptype <= {sh_ptype[7:0], i_data};
                        else if (idx == 6'd18) sh_hlen  <= i_data;
                        else if (idx == 6'd19) sh_plen  <= i_data;
                        else if (idx <= 6'd21) sh_oper  <= {sh_oper[7:0], i_data};
                        else if (idx <= 6'd27) sh_sha   <= {sh_sha[39:0], i_data};
                        else if (idx <= 6'd31) sh_spa   <= {sh_spa[23:0], i_data};
                        else if (idx <= 6'd37) sh_tha   <= {sh_tha[39:0], i_data};
                        else                   sh_tpa   <= {sh_tpa[23:0], i_data};
                        // index saturates at the last byte; the FSM leaves FIELDS there
                        if (idx == LAST_IDX) state <= WAIT_END;
                        else                 idx   <= idx + 6'd1;
                    end
                end
                WAIT_END: begin
                    if (!i_data_vl) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit / hold / drop bookkeeping for the visible packet slot
    always_ff @(posedge clk) begin
        if (rst) begin
            v_src        <= '0;
            v_sha        <= '0;
            v_tha        <= '0;
            v_spa        <= '0;
            v_tpa        <= '0;
            o_oper       <= '0;
            o_pkt_ready  <= 1'b0;
            o_pkt_strobe <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            o_pkt_strobe <= commit;
            if (commit) begin
                v_src       <= sh_src;
                v_sha       <= sh_sha;
                v_tha       <= sh_tha;
                v_spa       <= sh_spa;
                v_tpa       <= {sh_tpa[23:0], i_data};
                o_oper      <= sh_oper[1:0];
                o_pkt_ready <= 1'b1;
            end else if (i_ack) begin
                o_pkt_ready <= 1'b0;
            end
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Registered read-back mux
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_data <= '0;
        end else begin
            case (i_rd_addr)
                4'd0:    o_rd_data <= {drop_cnt, 22'h0, o_oper};
                4'd1:    o_rd_data <= v_sha[47:16];
                4'd2:    o_rd_data <= {16'h0, v_sha[15:0]};
                4'd3:    o_rd_data <= v_spa;
                4'd4:    o_rd_data <= v_tha[47:16];
                4'd5:    o_rd_data <= {16'h0, v_tha[15:0]};
                4'd6:    o_rd_data <= v_tpa;
                4'd7:    o_rd_data <= v_src[47:16];
                4'd8:    o_rd_data <= {16'h0, v_src[15:0]};
                default: o_rd_data <= 32'h0;
            endcase
        end
    end

endmodule

// File: doc/arp_rx_parser.md
ARP_RX_PARSER -- requirements
Module: arp_rx_parser

Interface
REQ-001 SHALL have parameter MAC_FILTER, default 1; 1 = accept only frames to i_my_mac or broadcast, 0 = accept any destination MAC.
REQ-002 SHALL have port clk  input  1  single clock for all logic (receive byte clock).
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have port i_data  input  8  GMII-style receive byte, preamble included.
REQ-005 SHALL have port i_data_vl  input  1  receive data valid; one byte per cycle while high.
REQ-006 SHALL have port i_my_mac  input  48  station MAC used by destination filter.
REQ-007 SHALL have port i_rd_addr  input  4  read-back register index.
REQ-008 SHALL have port o_rd_data  output  32  read-back data, 1-cycle registered latency.
REQ-009 SHALL have port i_ack  input  1  single-cycle pulse; consumer has read the captured packet.
REQ-010 SHALL have port o_pkt_ready  output  1  captured ARP packet held and unacknowledged.
REQ-011 SHALL have port o_pkt_strobe  output  1  one-cycle pulse when a new packet is committed.
REQ-012 SHALL have port o_oper  output  2  captured ARP operation (1 request, 2 reply).

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, FIELDS, WAIT_END.
REQ-014 IDLE -> PREAMBLE when i_data_vl=1 and i_data=8'h55; other bytes ignored.
REQ-015 PREAMBLE: 8'h55 stays; 8'hD5 -> FIELDS with byte index cleared to 0; any other byte -> WAIT_END.
REQ-016 FIELDS: byte index 0..41 increments once per valid byte; bytes 0-5 dst MAC, 6-11 src MAC, 12-13 EtherType, 14-41 ARP body (HTYPE, PTYPE, HLEN, PLEN, OPER, SHA, SPA, THA, TPA), all big-endian.
REQ-017 Fields SHALL be assembled in shadow registers; visible outputs change only on commit.
REQ-018 Packet valid iff EtherType=16'h0806, HTYPE=16'h0001, PTYPE=16'h0800, HLEN=8'd6, PLEN=8'd4, OPER in {1,2}, and destination passes filter (REQ-001).
REQ-019 On valid byte 41: valid packet commits (shadow -> visible, o_pkt_strobe=1 next cycle); state -> WAIT_END either way.
REQ-020 WAIT_END -> IDLE on first cycle with i_data_vl=0; trailing bytes (padding, FCS) ignored; FCS not checked.
REQ-021 i_data_vl=0 in PREAMBLE or FIELDS SHALL abort to IDLE without commit; visible registers unchanged.
REQ-022 o_pkt_ready set on commit, cleared by i_ack; commit and i_ack in the same cycle -> new packet latched, o_pkt_ready stays 1.
REQ-023 Commit while o_pkt_ready=1 and no i_ack SHALL drop the new packet, hold old data, and increment 8-bit drop counter, saturating at 8'hFF.
REQ-024 i_ack while o_pkt_ready=0 SHALL have no effect.
REQ-025 Read map (o_rd_data one cycle after i_rd_addr): 0 {drop_cnt, 22'h0, o_oper}; 1 SHA[47:16]; 2 {16'h0, SHA[15:0]}; 3 SPA; 4 THA[47:16]; 5 {16'h0, THA[15:0]}; 6 TPA; 7 src MAC[47:16]; 8 {16'h0, src MAC[15:0]}; 9-15 32'h0.
REQ-026 Byte index SHALL be 6 bits and never wrap within a frame; commit decision only at index 41.

Reset
REQ-027 rst=1 SHALL force state IDLE, byte index 0, all shadow and visible fields 0, drop counter 0, o_pkt_ready=0, o_pkt_strobe=0, o_oper=0, o_rd_data=0.
REQ-028 rst mid-frame SHALL discard the frame; receive resumes only at the next preamble after rst deasserts.

Verification
REQ-029 7x55, D5, broadcast ARP request SPA 192.168.1.10 TPA 192.168.1.1 -> o_pkt_strobe 1 cycle after byte 41, o_oper=1, addr 3 reads 32'hC0A8010A, addr 6 32'hC0A80101.
REQ-030 Same frame, dst 02:00:00:00:00:99, i_my_mac 02:00:00:00:00:01, MAC_FILTER=1 -> no strobe, o_pkt_ready=0; MAC_FILTER=0 -> commit.
REQ-031 i_data_vl dropped after byte 30 -> no commit, prior captured values unchanged on all read addresses.
REQ-032 Two valid ARP frames, no i_ack -> first frame data retained, addr 0 reads drop_cnt=1; 256 further drops -> drop_cnt=8'hFF.
REQ-033 EtherType 16'h0800 frame and OPER=3 frame -> no commit; following valid ARP reply -> o_oper=2.
REQ-034 i_ack coincident with commit cycle -> o_pkt_ready stays 1, new data visible; rst during byte 20 -> all outputs 0, next full frame commits normally.
